// File: rtl/sm_pkg.sv
// sm_pkg
// Shared types and default sizing for the sequential-multiplier feeder slice.
//   feeder_state_e : feeder FSM states
//   sm_pair_t      : operand pair {a, b, tag} at the default sizing
//   SM_*           : default parameter values used by sm_feeder / sm_operand_fifo
package sm_pkg;

    localparam int unsigned SM_WIDTH          = 16;
    localparam int unsigned SM_TAG_W          = 4;
    localparam int unsigned SM_FIFO_DEPTH     = 4;
    localparam int unsigned SM_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } feeder_state_e;

    typedef struct packed {
        logic [SM_WIDTH-1:0] a;
        logic [SM_WIDTH-1:0] b;
        logic [SM_TAG_W-1:0] tag;
    } sm_pair_t;

endpackage

// File: rtl/sm_operand_fifo.sv
// sm_operand_fifo
// Synchronous FIFO of operand-pair structs with a registered occupancy count.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (empties the FIFO)
//   push        : write push_data when not full (ignored while full)
//   push_data   : entry to write
//   pop         : drop the head entry when not empty
//   head        : current head entry (valid while !empty)
//   full, empty : derived from the registered count only
module sm_operand_fifo
    import sm_pkg::*;
#(
    parameter int unsigned DEPTH = SM_FIFO_DEPTH,
    parameter type         T     = sm_pair_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/sm_feeder.sv
// sm_feeder
// Front-end for the 16x16 sequential multiplier: buffers operand pairs from a
// valid/ready stream, runs one multiplication at a time and returns the product
// with its tag on a valid/ready result stream.
// Ports:
//   clk, reset                        : clock, asynchronous active-high reset
//   in_valid/in_ready                 : operand-pair input handshake (in_ready = !full)
//   in_multiplicand/in_multiplier/in_tag : operand pair and user tag
//   mul_start                         : one-cycle start pulse to the multiplier
//   mul_multiplicand/mul_multiplier   : operands, held from start until completion
//   mul_product/mul_ready             : multiplier result and idle/done flag
//   res_valid/res_ready               : result output handshake
//   res_product/res_tag/res_err       : result, tag, timeout flag
//   busy                              : FSM active or FIFO non-empty
// Configuration:
//   SM_FEEDER_TIMEOUT_EN : enables the per-operation watchdog (TIMEOUT_CYCLES);
//                          without it the wait states wait indefinitely and res_err is 0.
module sm_feeder
    import sm_pkg::*;
#(
    parameter int unsigned WIDTH          = SM_WIDTH,
    parameter int unsigned FIFO_DEPTH     = SM_FIFO_DEPTH,
    parameter int unsigned TAG_W          = SM_TAG_W,
    parameter int unsigned TIMEOUT_CYCLES = SM_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_multiplicand,
    input  logic [WIDTH-1:0]   in_multiplier,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_multiplicand,
    output logic [WIDTH-1:0]   mul_multiplier,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic               mul_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_product,
    output logic [TAG_W-1:0]   res_tag,
    output logic               res_err,
    output logic               busy
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } pair_t;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    pair_t fifo_in;
    pair_t fifo_head;
    logic  fifo_full;
    logic  fifo_empty;
    logic  pop;

    assign fifo_in = '{a: in_multiplicand, b: in_multiplier, tag: in_tag};

    sm_operand_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (pair_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (fifo_in),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    feeder_state_e      state_q, state_d;
    logic               start_q, start_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               res_valid_q, res_valid_d;
    logic [2*WIDTH-1:0] res_product_q, res_product_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic               res_free;

`ifdef SM_FEEDER_TIMEOUT_EN
    localparam int unsigned     CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_err_q, res_err_d;
    logic             waiting;
`endif

    always_comb begin
        state_d       = state_q;
        start_d       = 1'b0;
        a_d           = a_q;
        b_d           = b_q;
        tag_d         = tag_q;
        res_valid_d   = res_valid_q;
        res_product_d = res_product_q;
        res_tag_d     = res_tag_q;
        pop           = 1'b0;
`ifdef SM_FEEDER_TIMEOUT_EN
        cnt_d         = cnt_q;
        res_err_d     = res_err_q;
`endif
        // A result being accepted this cycle frees the register for a refill.
        res_free = !res_valid_q || res_ready;
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && mul_ready && res_free) begin
                    pop     = 1'b1;
                    a_d     = fifo_head.a;
                    b_d     = fifo_head.b;
                    tag_d   = fifo_head.tag;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef SM_FEEDER_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!mul_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (mul_ready) begin
                    res_valid_d   = 1'b1;
                    res_product_d = mul_product;
                    res_tag_d     = tag_q;
`ifdef SM_FEEDER_TIMEOUT_EN
                    res_err_d     = 1'b0;
`endif
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef SM_FEEDER_TIMEOUT_EN
        // Normal completion in WAIT_DONE takes priority over the watchdog.
        waiting = (state_q == ST_WAIT_BUSY) || ((state_q == ST_WAIT_DONE) && !mul_ready);
        if (waiting) begin
            if (cnt_q == CNT_LIMIT) begin
                res_valid_d   = 1'b1;
                res_product_d = '0;
                res_tag_d     = tag_q;
                res_err_d     = 1'b1;
                state_d       = ST_IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            tag_q         <= '0;
            res_valid_q   <= 1'b0;
            res_product_q <= '0;
            res_tag_q     <= '0;
`ifdef SM_FEEDER_TIMEOUT_EN
            cnt_q         <= '0;
            res_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            a_q           <= a_d;
            b_q           <= b_d;
            tag_q         <= tag_d;
            res_valid_q   <= res_valid_d;
            res_product_q <= res_product_d;
            res_tag_q     <= res_tag_d;
`ifdef SM_FEEDER_TIMEOUT_EN
            cnt_q         <= cnt_d;
            res_err_q     <= res_err_d;
`endif
        end
    end

    assign in_ready         = !fifo_full;
    assign mul_start        = start_q;
    assign mul_multiplicand = a_q;
    assign mul_multiplier   = b_q;
    assign res_valid        = res_valid_q;
    assign res_product      = res_product_q;
    assign res_tag          = res_tag_q;
    assign busy             = (state_q != ST_IDLE) || !fifo_empty;
`ifdef SM_FEEDER_TIMEOUT_EN
    assign res_err          = res_err_q;
`else
    assign res_err          = 1'b0;
`endif

endmodule

// File: tb/tb_sm_feeder.sv
// tb_sm_feeder
// Bench for sm_feeder with a behavioural sequential multiplier and a queue-based
// scoreboard of expected {a*b, tag} results in arrival order.
`timescale 1ns/1ps
module tb_sm_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_multiplicand;
    logic [15:0] in_multiplier;
    logic [3:0]  in_tag;
    logic        mul_start;
    logic [15:0] mul_multiplicand;
    logic [15:0] mul_multiplier;
    logic [31:0] mul_product;
    logic        mul_ready;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_product;
    logic [3:0]  res_tag;
    logic        res_err;
    logic        busy;

    always #5 clk = ~clk;

    sm_feeder #(
        .WIDTH          (16),
        .FIFO_DEPTH     (4),
        .TAG_W          (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_multiplicand  (in_multiplicand),
        .in_multiplier    (in_multiplier),
        .in_tag           (in_tag),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .mul_ready        (mul_ready),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_product      (res_product),
        .res_tag          (res_tag),
        .res_err          (res_err),
        .busy             (busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural multiplier ----------------
    bit          stuck_mode = 1'b0;
    bit          rand_lat   = 1'b0;
    int unsigned fixed_lat  = 3;
    int unsigned m_cnt;
    logic [15:0] m_a, m_b;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_ready   <= 1'b1;
            mul_product <= '0;
            m_cnt       <= 0;
            m_a         <= '0;
            m_b         <= '0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mul_ready   <= 1'b1;
                mul_product <= {16'h0, m_a} * {16'h0, m_b};
            end
        end else if (mul_start) begin
            m_a <= mul_multiplicand;
            m_b <= mul_multiplier;
            if (stuck_mode) begin
                mul_product <= 32'hDEAD_BEEF;
            end else begin
                mul_ready <= 1'b0;
                m_cnt     <= rand_lat ? $urandom_range(6, 1) : fixed_lat;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [31:0] prod;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] got_prod[$];
    int unsigned n_pushed  = 0;
    int unsigned n_results = 0;
    int unsigned n_starts  = 0;
    logic        prev_start = 1'b0;
    logic        prev_hold  = 1'b0;
    logic [31:0] prev_prod;
    logic [3:0]  prev_tag;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_start = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                e.prod = stuck_mode ? 32'h0 : (32'(in_multiplicand) * 32'(in_multiplier));
                e.tag  = in_tag;
                e.err  = stuck_mode;
                exp_q.push_back(e);
                n_pushed++;
            end
            if (mul_start) begin
                n_starts++;
                check("start_single_cycle", prev_start, 0);
            end
            prev_start = mul_start;
            if (m_cnt != 0) begin
                check("hold_multiplicand", mul_multiplicand, m_a);
                check("hold_multiplier", mul_multiplier, m_b);
            end
            if (prev_hold) begin
                check("stall_valid", res_valid, 1);
                check("stall_product", res_product, prev_prod);
                check("stall_tag", res_tag, prev_tag);
            end
            prev_hold = res_valid && !res_ready;
            prev_prod = res_product;
            prev_tag  = res_tag;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_product", res_product, e.prod);
                    check("res_tag", res_tag, e.tag);
                    check("res_err", res_err, e.err);
                end
                got_prod.push_back(res_product);
                n_results++;
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
        int unsigned n = 0;
        in_valid        = 1'b1;
        in_multiplicand = a;
        in_multiplier   = b;
        in_tag          = t;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int unsigned budget);
        int unsigned n  = 0;
        bit          ok = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !res_valid) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        check(tag, ok, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #800_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    bit drv_done;

    initial begin
        int unsigned s0, r0, n;
        reset           = 1'b1;
        in_valid        = 1'b0;
        in_multiplicand = '0;
        in_multiplier   = '0;
        in_tag          = '0;
        res_ready       = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_busy", busy, 0);
        check("rst_res_err", res_err, 0);
        check("rst_res_product", res_product, 0);
        check("rst_res_tag", res_tag, 0);
        check("rst_multiplicand", mul_multiplicand, 0);
        check("rst_multiplier", mul_multiplier, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single pair into idle block
        res_ready = 1'b1;
        s0 = n_starts;
        push(16'd3, 16'd5, 4'd1);
        wait_idle("t1_drain", 100);
        check("t1_starts", n_starts - s0, 1);
        check("t1_product", got_prod[$], 32'd15);

        // Extreme operands, in order
        s0 = n_starts;
        r0 = got_prod.size();
        push(16'hFFFF, 16'hFFFF, 4'd2);
        push(16'h0000, 16'h1234, 4'd3);
        wait_idle("t2_drain", 100);
        check("t2_starts", n_starts - s0, 2);
        check("t2_count", got_prod.size() - r0, 2);
        check("t2_first", got_prod[r0], 32'hFFFE_0001);
        check("t2_second", got_prod[r0 + 1], 32'h0);

        // Backpressure: FIFO fills, result held stable
        res_ready = 1'b0;
        r0 = n_results;
        for (int unsigned i = 0; i < 5; i++) begin
            push(16'(i + 2), 16'(i + 11), 4'(i + 4));
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t3_in_ready_low", in_ready, 0);
        check("t3_res_valid", res_valid, 1);
        check("t3_busy", busy, 1);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_idle("t3_drain", 200);
        check("t3_results", n_results - r0, 5);

        // Reset while the multiplier is working
        fixed_lat = 30;
        push(16'd9, 16'd9, 4'd5);
        n = 0;
        while (m_cnt == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_mul_busy_seen", (m_cnt != 0), 1);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("t4_res_valid", res_valid, 0);
        check("t4_mul_start", mul_start, 0);
        check("t4_busy", busy, 0);
        check("t4_in_ready", in_ready, 1);
        check("t4_multiplicand", mul_multiplicand, 0);
        check("t4_res_product", res_product, 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        fixed_lat = 3;
        r0 = n_results;
        push(16'd7, 16'd9, 4'd6);
        wait_idle("t4_drain", 100);
        check("t4_results", n_results - r0, 1);
        check("t4_product", got_prod[$], 32'd63);

`ifdef SM_FEEDER_TIMEOUT_EN
        // Watchdog: multiplier never acknowledges the start
        stuck_mode = 1'b1;
        push(16'd4, 16'd4, 4'd7);
        n = 0;
        while (!mul_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_timeout_latency", n, 65);
        wait_idle("t5_drain", 100);
        check("t5_product", got_prod[$], 32'h0);
        stuck_mode = 1'b0;
        @(posedge clk);
        #1;
`endif

        // Random traffic
        rand_lat = 1'b1;
        drv_done = 1'b0;
        r0 = n_results;
        s0 = n_pushed;
        fork
            begin
                for (int unsigned i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(2, 0)) begin
                        @(posedge clk);
                        #1;
                    end
                    push(16'($urandom), 16'($urandom), 4'($urandom));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    res_ready = ($urandom_range(3, 0) != 0);
                end
            end
        join
        res_ready = 1'b1;
        wait_idle("t6_drain", 3000);
        check("t6_pushed", n_pushed - s0, 1000);
        check("t6_results", n_results - r0, 1000);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
